// File: rtl/jesd204b_8b10b_pkg.sv
// 8b/10b code tables and constants shared by the JESD204B TX encoder.
// Each table holds the RD- code; the RD+ code is derived from it by the complement rule below.
package jesd204b_8b10b_pkg;

  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic       RD_MINUS = 1'b0;
  localparam logic       RD_PLUS  = 1'b1;

  // 5b/6b RD- codes, abcdei with a in bit 5
  function automatic logic [5:0] enc_6b_rdm(input logic [4:0] edcba);
    logic [5:0] c;
    case (edcba)
      5'd0:  c = 6'b100111;
      5'd1:  c = 6'b011101;
      5'd2:  c = 6'b101101;
      5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;
      5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;
      5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;
      5'd9:  c = 6'b100101;
      5'd10: c = 6'b010101;
      5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;
      5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;
      5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;
      5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;
      5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;
      5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;
      5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  function automatic logic unbal6(input logic [5:0] c);
    return $countones(c) != 3;
  endfunction

  function automatic logic unbal4(input logic [3:0] c);
    return $countones(c) != 2;
  endfunction

  // RD+ code is the complement for unbalanced codes and for the neutral-but-asymmetric D.07
  function automatic logic [5:0] enc_6b(input logic [4:0] edcba, input logic is_k28, input logic rd);
    logic [5:0] c;
    c = is_k28 ? 6'b001111 : enc_6b_rdm(edcba);
    if (rd == RD_PLUS && (unbal6(c) || c == 6'b111000))
      c = ~c;
    return c;
  endfunction

  // rd here is the RD after the 6b sub-block; K.x.1/2/5/6 use the complemented D code at RD-
  function automatic logic [3:0] enc_4b(input logic [2:0] hgf, input logic is_k,
                                        input logic use_a7, input logic rd);
    logic [3:0] c;
    case (hgf)
      3'd0: c = 4'b1011;
      3'd1: c = 4'b1001;
      3'd2: c = 4'b0101;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = 4'b1010;
      3'd6: c = 4'b0110;
      default: c = use_a7 ? 4'b0111 : 4'b1110;
    endcase
    if (is_k && rd == RD_MINUS &&
        (hgf == 3'd1 || hgf == 3'd2 || hgf == 3'd5 || hgf == 3'd6))
      c = ~c;
    if (rd == RD_PLUS && (unbal4(c) || hgf == 3'd3))
      c = ~c;
    return c;
  endfunction

  function automatic logic k_supported(input logic [7:0] chr);
    return (chr[4:0] == 5'd28) || (chr == 8'hF7) || (chr == 8'hFB) ||
           (chr == 8'hFD) || (chr == 8'hFE);
  endfunction

endpackage

// File: rtl/enc_8b10b_lookup.sv
// Combinational 8b/10b character lookup: character + K flag + RD in -> symbol, RD out, K error.
module enc_8b10b_lookup
  import jesd204b_8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       is_k,
  input  logic       rd_in,
  output logic [9:0] sym,
  output logic       rd_out,
  output logic       k_err
);

  logic       supported;
  logic [7:0] chr;
  logic [4:0] edcba;
  logic [2:0] hgf;
  logic [5:0] sb6;
  logic [3:0] sb4;
  logic       rd_mid;
  logic       use_a7;

  always_comb begin
    supported = !is_k || k_supported(data);
    chr       = supported ? data : K28_5;
    edcba     = chr[4:0];
    hgf       = chr[7:5];
    sb6       = enc_6b(edcba, is_k && (edcba == 5'd28), rd_in);
    rd_mid    = unbal6(sb6) ? ~rd_in : rd_in;
    // A7 avoids a run of five equal bits across the 6b/4b boundary
    use_a7    = is_k ||
                (rd_mid == RD_MINUS && (edcba == 5'd17 || edcba == 5'd18 || edcba == 5'd20)) ||
                (rd_mid == RD_PLUS  && (edcba == 5'd11 || edcba == 5'd13 || edcba == 5'd14));
    sb4       = enc_4b(hgf, is_k, use_a7, rd_mid);
    sym       = {sb6, sb4};
    rd_out    = unbal4(sb4) ? ~rd_mid : rd_mid;
    k_err     = !supported;
  end

endmodule

// File: rtl/tx_8b10b_encoder.sv
// Registered JESD204B TX 8b/10b encoder with valid/ready on both sides and running-disparity tracking.
// Define TX_8B10B_ENCODER_PIPE2_EN for a two-stage (lookup, output) pipeline with 2-cycle latency.
module tx_8b10b_encoder
  import jesd204b_8b10b_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_is_k,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] out_sym,
  output logic       out_k_err,
  output logic       out_rd
);

  logic       rd_state;
  logic [9:0] lk_sym;
  logic       lk_rd;
  logic       lk_k_err;
  logic       in_fire;

  enc_8b10b_lookup u_lookup (
    .data   (in_data),
    .is_k   (in_is_k),
    .rd_in  (rd_state),
    .sym    (lk_sym),
    .rd_out (lk_rd),
    .k_err  (lk_k_err)
  );

  assign in_fire = in_valid && in_ready;

`ifdef TX_8B10B_ENCODER_PIPE2_EN
  logic       vld_p0, vld_p1;
  logic [9:0] sym_p0, sym_p1;
  logic       k_err_p0, k_err_p1;
  logic       rd_p0, rd_p1;
  logic       advance;

  assign advance  = !vld_p1 || out_ready;
  assign in_ready = advance || !vld_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_MINUS;
      vld_p0   <= 1'b0;
      sym_p0   <= '0;
      k_err_p0 <= 1'b0;
      rd_p0    <= RD_MINUS;
      vld_p1   <= 1'b0;
      sym_p1   <= '0;
      k_err_p1 <= 1'b0;
      rd_p1    <= RD_MINUS;
    end else begin
      // stage 1 -> stage 2
      if (advance) begin
        vld_p1 <= vld_p0;
        if (vld_p0) begin
          sym_p1   <= sym_p0;
          k_err_p1 <= k_err_p0;
          rd_p1    <= rd_p0;
        end
      end
      // input -> stage 1
      if (in_fire) begin
        rd_state <= lk_rd;
        vld_p0   <= 1'b1;
        sym_p0   <= lk_sym;
        k_err_p0 <= lk_k_err;
        rd_p0    <= lk_rd;
      end else if (advance) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_sym   = sym_p1;
  assign out_k_err = k_err_p1;
  assign out_rd    = rd_p1;
`else
  logic       vld_p0;
  logic [9:0] sym_p0;
  logic       k_err_p0;

  assign in_ready = !vld_p0 || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_MINUS;
      vld_p0   <= 1'b0;
      sym_p0   <= '0;
      k_err_p0 <= 1'b0;
    end else if (in_fire) begin
      // input -> output register
      rd_state <= lk_rd;
      vld_p0   <= 1'b1;
      sym_p0   <= lk_sym;
      k_err_p0 <= lk_k_err;
    end else if (out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_valid = vld_p0;
  assign out_sym   = sym_p0;
  assign out_k_err = k_err_p0;
  assign out_rd    = rd_state;
`endif

endmodule

// File: tb/tb_tx_8b10b_encoder.sv
// Scoreboard bench for tx_8b10b_encoder: directed vectors, stall, reset flush and random data characters.
module tb_tx_8b10b_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_is_k = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] out_sym;
  logic       out_k_err;
  logic       out_rd;

  typedef struct packed {
    logic [9:0] sym;
    logic       kerr;
    logic       rd;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  logic m_rd = 1'b0;

  tx_8b10b_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_is_k   (in_is_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .out_k_err (out_k_err),
    .out_rd    (out_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference tables written out with both RD columns: {RD- code, RD+ code}
  function automatic logic [11:0] ref6(input logic [4:0] x);
    case (x)
      5'd0:  return {6'b100111, 6'b011000};
      5'd1:  return {6'b011101, 6'b100010};
      5'd2:  return {6'b101101, 6'b010010};
      5'd3:  return {6'b110001, 6'b110001};
      5'd4:  return {6'b110101, 6'b001010};
      5'd5:  return {6'b101001, 6'b101001};
      5'd6:  return {6'b011001, 6'b011001};
      5'd7:  return {6'b111000, 6'b000111};
      5'd8:  return {6'b111001, 6'b000110};
      5'd9:  return {6'b100101, 6'b100101};
      5'd10: return {6'b010101, 6'b010101};
      5'd11: return {6'b110100, 6'b110100};
      5'd12: return {6'b001101, 6'b001101};
      5'd13: return {6'b101100, 6'b101100};
      5'd14: return {6'b011100, 6'b011100};
      5'd15: return {6'b010111, 6'b101000};
      5'd16: return {6'b011011, 6'b100100};
      5'd17: return {6'b100011, 6'b100011};
      5'd18: return {6'b010011, 6'b010011};
      5'd19: return {6'b110010, 6'b110010};
      5'd20: return {6'b001011, 6'b001011};
      5'd21: return {6'b101010, 6'b101010};
      5'd22: return {6'b011010, 6'b011010};
      5'd23: return {6'b111010, 6'b000101};
      5'd24: return {6'b110011, 6'b001100};
      5'd25: return {6'b100110, 6'b100110};
      5'd26: return {6'b010110, 6'b010110};
      5'd27: return {6'b110110, 6'b001001};
      5'd28: return {6'b001110, 6'b001110};
      5'd29: return {6'b101110, 6'b010001};
      5'd30: return {6'b011110, 6'b100001};
      default: return {6'b101011, 6'b010100};
    endcase
  endfunction

  function automatic logic [7:0] ref4(input logic [2:0] y, input logic a7);
    case (y)
      3'd0: return {4'b1011, 4'b0100};
      3'd1: return {4'b1001, 4'b1001};
      3'd2: return {4'b0101, 4'b0101};
      3'd3: return {4'b1100, 4'b0011};
      3'd4: return {4'b1101, 4'b0010};
      3'd5: return {4'b1010, 4'b1010};
      3'd6: return {4'b0110, 4'b0110};
      default: return a7 ? {4'b0111, 4'b1000} : {4'b1110, 4'b0001};
    endcase
  endfunction

  task automatic model_d(input logic [7:0] d, input logic rd, output logic [9:0] s, output logic r);
    logic [11:0] p6;
    logic [7:0]  p4;
    logic [5:0]  c6;
    logic [3:0]  c4;
    logic        mid;
    logic        a7;
    p6  = ref6(d[4:0]);
    c6  = rd ? p6[5:0] : p6[11:6];
    mid = ($countones(c6) != 3) ? ~rd : rd;
    a7  = (!mid && (d[4:0] == 5'd17 || d[4:0] == 5'd18 || d[4:0] == 5'd20)) ||
          ( mid && (d[4:0] == 5'd11 || d[4:0] == 5'd13 || d[4:0] == 5'd14));
    p4  = ref4(d[7:5], a7);
    c4  = mid ? p4[3:0] : p4[7:4];
    s   = {c6, c4};
    r   = ($countones(c4) != 2) ? ~mid : mid;
  endtask

  // Presents a character and queues its expected symbol when the transfer is certain
  task automatic send(input logic [7:0] d, input logic k, input logic [9:0] s,
                      input logic ke, input logic r);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_is_k  = k;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept data=%0h", d);
      in_valid = 1'b0;
      return;
    end
    sb_q.push_back('{sym: s, kerr: ke, rd: r});
    m_rd = r;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_symbol actual=%b required=none", out_sym);
        end else begin
          e = sb_q.pop_front();
          check("symbol{sym,kerr,rd}", 32'({out_sym, out_k_err, out_rd}),
                32'({e.sym, e.kerr, e.rd}));
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] d;
    logic [9:0] s;
    logic       r;
    int         t0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_sym", 32'(out_sym), 32'h000);
    check("reset_out_k_err", 32'(out_k_err), 32'd0);
    check("reset_out_rd", 32'(out_rd), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    send(8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0);  // D.0.0 RD-
    send(8'hBC, 1'b1, 10'b0011111010, 1'b0, 1'b1);  // K28.5 RD-
    send(8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0);  // K28.5 RD+
    send(8'hF1, 1'b0, 10'b1000110111, 1'b0, 1'b1);  // D.17.7 A7
    send(8'hEB, 1'b0, 10'b1101001000, 1'b0, 1'b0);  // D.11.7 A7
    send(8'hE3, 1'b0, 10'b1100011110, 1'b0, 1'b1);  // D.3.7 P7
    send(8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0);  // K28.5 RD+
    send(8'h00, 1'b1, 10'b0011111010, 1'b1, 1'b1);  // unsupported K -> K28.5
    send(8'h1C, 1'b1, 10'b1100001011, 1'b0, 1'b1);  // K28.0 RD+
    send(8'hFC, 1'b1, 10'b1100000111, 1'b0, 1'b1);  // K28.7 RD+
    send(8'hF7, 1'b1, 10'b0001010111, 1'b0, 1'b1);  // K23.7 RD+
    send(8'h7C, 1'b1, 10'b1100001100, 1'b0, 1'b0);  // K28.3 RD+
    send(8'h3C, 1'b1, 10'b0011111001, 1'b0, 1'b1);  // K28.1 RD-

    // Stall with a pending character behind the held symbol
    send(8'h00, 1'b0, 10'b0110001011, 1'b0, 1'b1);  // D.0.0 RD+
    out_ready = 1'b0;
    in_data   = 8'hB5;
    in_is_k   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_sym", 32'(out_sym), 32'(10'b0110001011));
      check("stall_out_rd", 32'(out_rd), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b1);  // D.21.5 neutral

    t0 = cycle;
    for (int i = 0; i < 100; i++) begin
      d = 8'($urandom);
      model_d(d, m_rd, s, r);
      send(d, 1'b0, s, 1'b0, r);
    end
    check("throughput_cycles", 32'(cycle - t0), 32'd100);

    // Reset while a symbol is held at RD+
    if (m_rd) send(8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0);
    send(8'hBC, 1'b1, 10'b0011111010, 1'b0, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    check("pre_reset_out_rd", 32'(out_rd), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_rd", 32'(out_rd), 32'd0);
    check("flush_out_sym", 32'(out_sym), 32'h000);
    @(posedge clk);
    #1;
    send(8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0);
    in_valid = 1'b0;

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_out_sym_hold", 32'(out_sym), 32'(10'b1001110100));
    check("idle_in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
